// File: rtl/forward_ctrl.sv
// forward_ctrl: execute-stage hazard and forwarding controller.
//
// Tracks the destination tags of the instructions ahead of the one in ID.
// For each ID operand it picks an ALU input source and registers it as a
// one-hot select when ID/EX loads. It also stalls a load-use pair for one
// cycle and inserts a bubble into ID/EX.
//
// Ports:
//   clock, reset             pipeline clock; synchronous active-high reset
//   pipe_hold                global freeze; no state or select changes
//   id_valid                 ID holds a real instruction
//   id_rd_top/bot            ID reads top/bot source operand
//   id_src_top/bot           ID source register addresses
//   id_wr_top/bot            ID writes top/bot result
//   id_dst_top/bot           ID destination register addresses
//   id_is_load               ID result only available at MEM/WB
//   alu_input_sel_top/bot    registered one-hot ALU mux selects
//                            00001 own, 00010 ex_mem_top, 00100 ex_mem_bot,
//                            01000 mem_wb_top, 10000 mem_wb_bot
//   stall                    combinational load-use stall request
//   bubble                   stall & ~pipe_hold; ID/EX loads a NOP
//   stall_count              bubbles inserted, saturating (optional)
//
// Build option: define FORWARD_CTRL_STALL_CNT_EN to add stall_count.
//
// The MEM/WB tag slot only matters to the instruction already in EX, whose
// select was fixed a cycle earlier, so it is never consulted and is not kept.
// Write enables and the load flag are stored already gated by valid, which
// makes a separate valid bit unnecessary.

module forward_ctrl #(
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pipe_hold,
  input  logic                  id_valid,
  input  logic                  id_rd_top,
  input  logic                  id_rd_bot,
  input  logic [REG_ADDR_W-1:0] id_src_top,
  input  logic [REG_ADDR_W-1:0] id_src_bot,
  input  logic                  id_wr_top,
  input  logic                  id_wr_bot,
  input  logic [REG_ADDR_W-1:0] id_dst_top,
  input  logic [REG_ADDR_W-1:0] id_dst_bot,
  input  logic                  id_is_load,
  output logic [4:0]            alu_input_sel_top,
  output logic [4:0]            alu_input_sel_bot,
  output logic                  stall,
  output logic                  bubble
`ifdef FORWARD_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]           stall_count
`endif
);

  localparam logic [4:0] SEL_OWN     = 5'b00001;
  localparam logic [4:0] SEL_EXM_TOP = 5'b00010;
  localparam logic [4:0] SEL_EXM_BOT = 5'b00100;
  localparam logic [4:0] SEL_MWB_TOP = 5'b01000;
  localparam logic [4:0] SEL_MWB_BOT = 5'b10000;

  logic                  idex_wr_top_q, idex_wr_top_d;
  logic                  idex_wr_bot_q, idex_wr_bot_d;
  logic [REG_ADDR_W-1:0] idex_dst_top_q, idex_dst_top_d;
  logic [REG_ADDR_W-1:0] idex_dst_bot_q, idex_dst_bot_d;
  logic                  idex_load_q, idex_load_d;
  logic                  exmem_wr_top_q, exmem_wr_bot_q;
  logic [REG_ADDR_W-1:0] exmem_dst_top_q, exmem_dst_bot_q;
  logic [4:0]            sel_top_q, sel_top_d;
  logic [4:0]            sel_bot_q, sel_bot_d;

  logic hit_top, hit_bot, take_id;

  // Any read source that an IDEX write would satisfy.
  assign hit_top = id_rd_top &
                   ((idex_wr_top_q & (idex_dst_top_q == id_src_top)) |
                    (idex_wr_bot_q & (idex_dst_bot_q == id_src_top)));
  assign hit_bot = id_rd_bot &
                   ((idex_wr_top_q & (idex_dst_top_q == id_src_bot)) |
                    (idex_wr_bot_q & (idex_dst_bot_q == id_src_bot)));

  assign stall   = idex_load_q & id_valid & (hit_top | hit_bot);
  assign bubble  = stall & ~pipe_hold;
  assign take_id = id_valid & ~stall;

  always_comb begin
    idex_wr_top_d  = take_id & id_wr_top;
    idex_wr_bot_d  = take_id & id_wr_bot;
    idex_dst_top_d = id_dst_top;
    idex_dst_bot_d = id_dst_bot;
    idex_load_d    = take_id & id_is_load;
  end

  // Newer stage first, top before bot within a stage.
  always_comb begin
    sel_top_d = SEL_OWN;
    if (take_id && id_rd_top) begin
      if (idex_wr_top_q && idex_dst_top_q == id_src_top)        sel_top_d = SEL_EXM_TOP;
      else if (idex_wr_bot_q && idex_dst_bot_q == id_src_top)   sel_top_d = SEL_EXM_BOT;
      else if (exmem_wr_top_q && exmem_dst_top_q == id_src_top) sel_top_d = SEL_MWB_TOP;
      else if (exmem_wr_bot_q && exmem_dst_bot_q == id_src_top) sel_top_d = SEL_MWB_BOT;
    end
  end

  always_comb begin
    sel_bot_d = SEL_OWN;
    if (take_id && id_rd_bot) begin
      if (idex_wr_top_q && idex_dst_top_q == id_src_bot)        sel_bot_d = SEL_EXM_TOP;
      else if (idex_wr_bot_q && idex_dst_bot_q == id_src_bot)   sel_bot_d = SEL_EXM_BOT;
      else if (exmem_wr_top_q && exmem_dst_top_q == id_src_bot) sel_bot_d = SEL_MWB_TOP;
      else if (exmem_wr_bot_q && exmem_dst_bot_q == id_src_bot) sel_bot_d = SEL_MWB_BOT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idex_wr_top_q   <= 1'b0;
      idex_wr_bot_q   <= 1'b0;
      idex_dst_top_q  <= '0;
      idex_dst_bot_q  <= '0;
      idex_load_q     <= 1'b0;
      exmem_wr_top_q  <= 1'b0;
      exmem_wr_bot_q  <= 1'b0;
      exmem_dst_top_q <= '0;
      exmem_dst_bot_q <= '0;
      sel_top_q       <= SEL_OWN;
      sel_bot_q       <= SEL_OWN;
    end else if (!pipe_hold) begin
      exmem_wr_top_q  <= idex_wr_top_q;
      exmem_wr_bot_q  <= idex_wr_bot_q;
      exmem_dst_top_q <= idex_dst_top_q;
      exmem_dst_bot_q <= idex_dst_bot_q;
      idex_wr_top_q   <= idex_wr_top_d;
      idex_wr_bot_q   <= idex_wr_bot_d;
      idex_dst_top_q  <= idex_dst_top_d;
      idex_dst_bot_q  <= idex_dst_bot_d;
      idex_load_q     <= idex_load_d;
      sel_top_q       <= sel_top_d;
      sel_bot_q       <= sel_bot_d;
    end
  end

  assign alu_input_sel_top = sel_top_q;
  assign alu_input_sel_bot = sel_bot_q;

`ifdef FORWARD_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // bubble already excludes hold cycles, so a held stall is counted once.
  always_ff @(posedge clock) begin
    if (reset)
      stall_cnt_q <= '0;
    else if (bubble && stall_cnt_q != 16'hFFFF)
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: doc/forward_ctrl.md
# forward_ctrl

Hazard and forwarding controller for the execute stage. Tracks destination-register tags of the instructions in ID/EX, EX/MEM and MEM/WB. For the instruction entering EX it produces registered one-hot select codes for the ALU input mux. It also detects load-use hazards and requests a one-cycle stall with a bubble inserted into ID/EX.

## Interface
Parameters:
- REG_ADDR_W, 4, register-file address width.

Ports:
- clock  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- pipe_hold  in  1  global freeze from memory/fetch; all state and outputs held.
- id_valid  in  1  ID stage holds a real instruction.
- id_rd_top, id_rd_bot  in  1 each  instruction reads top/bot source operand.
- id_src_top, id_src_bot  in  REG_ADDR_W each  source register addresses.
- id_wr_top, id_wr_bot  in  1 each  instruction writes top/bot result.
- id_dst_top, id_dst_bot  in  REG_ADDR_W each  destination register addresses.
- id_is_load  in  1  result comes from data memory and is valid only at MEM/WB.
- alu_input_sel_top, alu_input_sel_bot  out  5 each  one-hot mux selects, registered.
- stall  out  1  combinational; upstream holds PC and IF/ID this cycle.
- bubble  out  1  combinational; equals stall & ~pipe_hold, so ID/EX loads a NOP on the next edge.
- stall_count  out  16  present only with FORWARD_CTRL_STALL_CNT_EN.

## Operation
- Select encoding: 00001 = own ID/EX operand, 00010 = ex_mem_top, 00100 = ex_mem_bot, 01000 = mem_wb_top, 10000 = mem_wb_bot. No other code is ever driven.
- State: three tag slots, IDEX, EXMEM and MEMWB. Each slot holds {wr_top, wr_bot, dst_top, dst_bot, is_load}, each gated by valid.
- Load-use hazard, evaluated on current inputs and state:
  - IDEX.valid & IDEX.is_load.
  - id_valid, and a source that is read (rd_x) equals an IDEX destination whose write enable is set.
  - The hazard drives stall=1.
- Advance on an edge where ~pipe_hold:
  - MEMWB<=EXMEM and EXMEM<=IDEX.
  - IDEX<=ID fields when id_valid & ~stall. Otherwise IDEX<=invalid (bubble).
- Select computation at advance, per source x (top, bot), first match wins:
  - If (~id_valid | stall | ~id_rd_x), select 00001.
  - IDEX.wr_top & dst_top==src_x, select 00010.
  - IDEX.wr_bot & dst_bot==src_x, select 00100.
  - EXMEM.wr_top & dst_top==src_x, select 01000.
  - EXMEM.wr_bot & dst_bot==src_x, select 10000.
  - Else select 00001.
  - Only valid slots match.
- Priority rules:
  - Newer stage beats older.
  - Within a stage, top beats bot. This covers an instruction with dst_top==dst_bot.
- A load in IDEX never yields 00010/00100, because the hazard stalls first.
- A load one slot older than the consumer (in EXMEM at ID time) forwards from MEM/WB without stalling.

## Timing
- Reset values:
  - All slots invalid.
  - alu_input_sel_top = alu_input_sel_bot = 5'b00001.
  - stall = bubble = 0 once reset deasserts with no ID input. stall_count = 0.
- Select latency: computed during the instruction's ID cycle and registered at the same edge that loads ID/EX. The select is therefore valid for the whole EX cycle of that instruction.
- Stall lasts exactly one cycle per load-use pair. On the following cycle IDEX holds the bubble, so the hazard clears and the consumer selects 01000/10000.
- pipe_hold=1:
  - No slot, select or counter changes.
  - stall is still reported, but bubble=0.
  - A hazard persisting through the hold is acted on when the hold drops.
- reset has priority over pipe_hold and any in-flight stall. Reset mid-stall clears the bubble and all tags.

## Configuration
- FORWARD_CTRL_STALL_CNT_EN defined:
  - stall_count port exists.
  - Increments on each edge with bubble=1 and saturates at 16'hFFFF.
  - Cleared by reset.
- FORWARD_CTRL_STALL_CNT_EN undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset, then idle for 3 cycles -> both selects 00001, stall=0, stall_count=0.
- I1 writes top r3. Next cycle I2 reads top r3 -> in I2's EX cycle, sel_top=00010, sel_bot=00001, no stall.
- I1 writes bot r5, I2 is unrelated, I3 reads bot r5 -> sel_bot=10000 during I3's EX cycle.
- Load writing top r2, immediately followed by a reader of top r2 -> stall=bubble=1 for one cycle. The following EX cycle has sel 00001 (bubble). The consumer's EX cycle has sel_top=01000, and stall_count=1.
- I1 writes top r4, I2 writes bot r4, I3 reads r4 -> sel=00100 (newest wins). I1 with dst_top=dst_bot=r6, then a reader of r6 -> sel=00010.
- Load-use hazard with pipe_hold=1 for 2 cycles -> selects and tags frozen, bubble=0, stall=1 throughout. Once the hold drops, a single bubble is inserted. Assert reset during that stall -> selects 00001, no bubble follows.
